// File: rtl/cplx_addsub_pipe.sv
// Complex a+b / a-b on re and im, 2-cycle latency, full throughput; optional clamp to input width via CPLX_ADDSUB_SAT_EN.
// Global stall: when dout_valid & ~dout_ready every stage holds and din_ready drops.
module cplx_addsub_pipe #(
   parameter int SIGN_BIT = 1,
   parameter int INT_BIT  = 6,
   parameter int FLT_BIT  = 6,
   parameter int CNT_W    = 16,
   localparam int DW      = SIGN_BIT + INT_BIT + FLT_BIT,
`ifdef CPLX_ADDSUB_SAT_EN
   localparam int OW      = DW
`else
   localparam int OW      = DW + 1
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             mode,
   input  logic [DW-1:0]    din_a_re,
   input  logic [DW-1:0]    din_a_im,
   input  logic [DW-1:0]    din_b_re,
   input  logic [DW-1:0]    din_b_im,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [OW-1:0]    dout_re,
   output logic [OW-1:0]    dout_im,
   output logic             dout_ovf,
   input  logic             sat_clr,
   output logic [CNT_W-1:0] sat_cnt
);
   localparam int EW = DW + 1;

   logic             en;
   logic             s1_vld_q, s1_vld_d, s1_mode_q, s1_mode_d;
   logic [EW-1:0]    s1_a_re_q, s1_a_re_d, s1_a_im_q, s1_a_im_d;
   logic [EW-1:0]    s1_b_re_q, s1_b_re_d, s1_b_im_q, s1_b_im_d;
   logic             s2_vld_q, s2_vld_d;
   logic [OW-1:0]    re_q, re_d, im_q, im_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
   logic [EW-1:0]    sum_re, sum_im;

   function automatic logic [EW-1:0] addsub(input logic m, input logic [EW-1:0] a,
                                            input logic [EW-1:0] b);
      return a + (m ? ~b : b) + {{(EW-1){1'b0}}, m};
   endfunction

`ifdef CPLX_ADDSUB_SAT_EN
   function automatic logic ovf_of(input logic [EW-1:0] s);
      return s[DW] ^ s[DW-1];
   endfunction

   function automatic logic [DW-1:0] clamp(input logic [EW-1:0] s);
      if (!ovf_of(s))
         return s[DW-1:0];
      return s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
   endfunction
`else
   logic unused_sat_clr;
   assign unused_sat_clr = sat_clr;
`endif

   assign en        = ~s2_vld_q | dout_ready;
   assign din_ready = en;
   assign sum_re    = addsub(s1_mode_q, s1_a_re_q, s1_b_re_q);
   assign sum_im    = addsub(s1_mode_q, s1_a_im_q, s1_b_im_q);

   always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_mode_d = s1_mode_q;
      s1_a_re_d = s1_a_re_q;
      s1_a_im_d = s1_a_im_q;
      s1_b_re_d = s1_b_re_q;
      s1_b_im_d = s1_b_im_q;
      s2_vld_d  = s2_vld_q;
      re_d      = re_q;
      im_d      = im_q;
      ovf_d     = ovf_q;
      sat_cnt_d = sat_cnt_q;
      if (en) begin
         s1_vld_d = din_valid;
         s2_vld_d = s1_vld_q;
         if (din_valid) begin
            s1_mode_d = mode;
            s1_a_re_d = {din_a_re[DW-1], din_a_re};
            s1_a_im_d = {din_a_im[DW-1], din_a_im};
            s1_b_re_d = {din_b_re[DW-1], din_b_re};
            s1_b_im_d = {din_b_im[DW-1], din_b_im};
         end
         if (s1_vld_q) begin
`ifdef CPLX_ADDSUB_SAT_EN
            re_d  = clamp(sum_re);
            im_d  = clamp(sum_im);
            ovf_d = ovf_of(sum_re) | ovf_of(sum_im);
`else
            re_d  = sum_re;
            im_d  = sum_im;
            ovf_d = 1'b0;
`endif
         end
      end
`ifdef CPLX_ADDSUB_SAT_EN
      // Clear beats a same-cycle increment; the counter sticks at all-ones.
      if (sat_clr)
         sat_cnt_d = '0;
      else if (s2_vld_q && dout_ready && ovf_q && !(&sat_cnt_q))
         sat_cnt_d = sat_cnt_q + CNT_W'(1);
`else
      sat_cnt_d = '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_mode_q <= 1'b0;
         s1_a_re_q <= '0;
         s1_a_im_q <= '0;
         s1_b_re_q <= '0;
         s1_b_im_q <= '0;
         s2_vld_q  <= 1'b0;
         re_q      <= '0;
         im_q      <= '0;
         ovf_q     <= 1'b0;
         sat_cnt_q <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_mode_q <= s1_mode_d;
         s1_a_re_q <= s1_a_re_d;
         s1_a_im_q <= s1_a_im_d;
         s1_b_re_q <= s1_b_re_d;
         s1_b_im_q <= s1_b_im_d;
         s2_vld_q  <= s2_vld_d;
         re_q      <= re_d;
         im_q      <= im_d;
         ovf_q     <= ovf_d;
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign dout_valid = s2_vld_q;
   assign dout_re    = re_q;
   assign dout_im    = im_q;
   assign dout_ovf   = ovf_q;
   assign sat_cnt    = sat_cnt_q;
endmodule

// File: tb/tb_cplx_addsub_pipe.sv
// Bench for cplx_addsub_pipe: directed corner beats plus a randomized stream checked
// against an integer-arithmetic model with an in-order expected-result queue.
module tb_cplx_addsub_pipe;
   localparam int DW    = 13;
   localparam int CNT_W = 4;
`ifdef CPLX_ADDSUB_SAT_EN
   localparam int OW    = DW;
`else
   localparam int OW    = DW + 1;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             din_valid, din_ready, mode;
   logic [DW-1:0]    din_a_re, din_a_im, din_b_re, din_b_im;
   logic             dout_valid, dout_ready;
   logic [OW-1:0]    dout_re, dout_im;
   logic             dout_ovf, sat_clr;
   logic [CNT_W-1:0] sat_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int model_cnt = 0;
   int delivered = 0;
   logic [OW-1:0] q_re[$];
   logic [OW-1:0] q_im[$];
   logic          q_ovf[$];

   always #5 clk = ~clk;

   cplx_addsub_pipe #(.SIGN_BIT(1), .INT_BIT(6), .FLT_BIT(6), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .din_valid(din_valid), .din_ready(din_ready), .mode(mode),
      .din_a_re(din_a_re), .din_a_im(din_a_im), .din_b_re(din_b_re), .din_b_im(din_b_im),
      .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_re(dout_re), .dout_im(dout_im), .dout_ovf(dout_ovf),
      .sat_clr(sat_clr), .sat_cnt(sat_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Signed integer result of a+b or a-b, optionally clamped to DW bits.
   function automatic logic [OW-1:0] ref_part(input logic m, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b, output logic o);
      int sa, sb, r, hi, lo;
      sa = int'($signed(a));
      sb = int'($signed(b));
      hi = (1 << (DW-1)) - 1;
      lo = -(1 << (DW-1));
      r  = m ? sa - sb : sa + sb;
      o  = 1'b0;
`ifdef CPLX_ADDSUB_SAT_EN
      if (r > hi) begin r = hi; o = 1'b1; end
      else if (r < lo) begin r = lo; o = 1'b1; end
`endif
      return r[OW-1:0];
   endfunction

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic step(output logic acc);
      logic o_re, o_im, eo;
      logic [OW-1:0] er, ei;
      #1;
      chk("sat_cnt", 32'(sat_cnt), 32'(model_cnt));
      chk("din_ready", 32'(din_ready), 32'(!dout_valid || dout_ready));
      if (dout_valid && dout_ready) begin
         chk("beat_expected", 32'(q_re.size() != 0), 32'(1));
         if (q_re.size() != 0) begin
            er = q_re.pop_front();
            ei = q_im.pop_front();
            eo = q_ovf.pop_front();
            chk("re", 32'(dout_re), 32'(er));
            chk("im", 32'(dout_im), 32'(ei));
            chk("ovf", 32'(dout_ovf), 32'(eo));
            delivered++;
            if (eo && model_cnt < (1 << CNT_W) - 1)
               model_cnt++;
         end
      end
      if (sat_clr)
         model_cnt = 0;
      acc = din_valid && din_ready;
      if (acc) begin
         q_re.push_back(ref_part(mode, din_a_re, din_b_re, o_re));
         q_im.push_back(ref_part(mode, din_a_im, din_b_im, o_im));
         q_ovf.push_back(o_re | o_im);
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic m, input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                        input logic [DW-1:0] br, input logic [DW-1:0] bi);
      din_valid = 1'b1;
      mode      = m;
      din_a_re  = ar;
      din_a_im  = ai;
      din_b_re  = br;
      din_b_im  = bi;
   endtask

   function automatic logic [DW-1:0] rnd_val();
      case ($urandom_range(0, 5))
         0:       return {1'b0, {(DW-1){1'b1}}};
         1:       return {1'b1, {(DW-1){1'b0}}};
         default: return DW'($urandom);
      endcase
   endfunction

   task automatic drive_rand();
      drive(1'($urandom_range(0, 1)), rnd_val(), rnd_val(), rnd_val(), rnd_val());
   endtask

   task automatic drain();
      logic acc;
      int guard = 0;
      din_valid  = 1'b0;
      dout_ready = 1'b1;
      while (q_re.size() != 0 && guard < 200) begin
         step(acc);
         guard++;
      end
      chk("drain_empty", 32'(q_re.size()), 32'(0));
   endtask

   // One beat into an empty pipe: checks 2-cycle latency and fixed expected values.
   task automatic directed(input string tag, input logic m,
                           input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                           input logic [DW-1:0] br, input logic [DW-1:0] bi,
                           input logic [OW-1:0] er, input logic [OW-1:0] ei, input logic eo);
      logic acc;
      dout_ready = 1'b1;
      drive(m, ar, ai, br, bi);
      step(acc);
      chk({tag, "_acc"}, 32'(acc), 32'(1));
      din_valid = 1'b0;
      #1 chk({tag, "_early"}, 32'(dout_valid), 32'(0));
      step(acc);
      #1;
      chk({tag, "_vld"}, 32'(dout_valid), 32'(1));
      chk({tag, "_re"}, 32'(dout_re), 32'(er));
      chk({tag, "_im"}, 32'(dout_im), 32'(ei));
      chk({tag, "_ovf"}, 32'(dout_ovf), 32'(eo));
      step(acc);
   endtask

   initial begin
      logic acc;
      int idx, cyc, base, guard, exp_cnt;
      rst_n = 1'b0; din_valid = 1'b0; dout_ready = 1'b0; sat_clr = 1'b0; mode = 1'b0;
      din_a_re = '0; din_a_im = '0; din_b_re = '0; din_b_im = '0;
      repeat (2) @(negedge clk);
      chk("rst_vld", 32'(dout_valid), 32'(0));
      chk("rst_rdy", 32'(din_ready), 32'(1));
      chk("rst_re", 32'(dout_re), 32'(0));
      chk("rst_cnt", 32'(sat_cnt), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);

`ifdef CPLX_ADDSUB_SAT_EN
      directed("t1", 1'b0, 13'h0FFF, 13'h0001, 13'h0FFF, 13'h1FFF, 13'h0FFF, 13'h0000, 1'b1);
      #1 chk("t1_cnt", 32'(sat_cnt), 32'(1));
      directed("t2", 1'b1, 13'h1000, 13'h0000, 13'h0FFF, 13'h0000, 13'h1000, 13'h0000, 1'b1);
`else
      directed("t1", 1'b0, 13'h0FFF, 13'h0001, 13'h0FFF, 13'h1FFF, 14'h1FFE, 14'h0000, 1'b0);
      #1 chk("t1_cnt", 32'(sat_cnt), 32'(0));
      directed("t2", 1'b1, 13'h1000, 13'h0000, 13'h0FFF, 13'h0000, 14'h2001, 14'h0000, 1'b0);
`endif

      // T3: stall the output after the first cycle, then release it.
      idx = 0; cyc = 0; base = delivered;
      while (idx < 5 && cyc < 100) begin
         drive_rand();
         dout_ready = (cyc == 0) || (cyc >= 6);
         if (cyc == 4) begin
            #1;
            chk("t3_stall_vld", 32'(dout_valid), 32'(1));
            chk("t3_stall_rdy", 32'(din_ready), 32'(0));
         end
         step(acc);
         if (acc) idx++;
         cyc++;
      end
      drain();
      chk("t3_count", 32'(delivered - base), 32'(5));

      // T4: saturate the event counter, then clear it on an overflowing handshake.
      idx = 0; guard = 0;
      while (idx < 20 && guard < 200) begin
         drive(1'b0, 13'h0FFF, 13'h0000, 13'h0FFF, 13'h0000);
         step(acc);
         if (acc) idx++;
         guard++;
      end
      drain();
`ifdef CPLX_ADDSUB_SAT_EN
      exp_cnt = 15;
`else
      exp_cnt = 0;
`endif
      #1 chk("t4_hold", 32'(sat_cnt), 32'(exp_cnt));
      drive(1'b0, 13'h0FFF, 13'h0000, 13'h0FFF, 13'h0000);
      step(acc);
      din_valid = 1'b0;
      step(acc);
      sat_clr = 1'b1;
      #1 chk("t4_clr_vld", 32'(dout_valid), 32'(1));
      step(acc);
      sat_clr = 1'b0;
      #1 chk("t4_clr", 32'(sat_cnt), 32'(0));

      // T5: reset with two beats in flight.
      dout_ready = 1'b1;
      drive_rand(); step(acc);
      drive_rand(); step(acc);
      din_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      q_re.delete(); q_im.delete(); q_ovf.delete();
      model_cnt = 0;
      #1;
      chk("t5_vld", 32'(dout_valid), 32'(0));
      chk("t5_re", 32'(dout_re), 32'(0));
      chk("t5_im", 32'(dout_im), 32'(0));
      chk("t5_ovf", 32'(dout_ovf), 32'(0));
      chk("t5_cnt", 32'(sat_cnt), 32'(0));
      chk("t5_rdy", 32'(din_ready), 32'(1));
`ifdef CPLX_ADDSUB_SAT_EN
      directed("t5_post", 1'b0, 13'h0010, 13'h1FF0, 13'h0001, 13'h0003, 13'h0011, 13'h1FF3, 1'b0);
`else
      directed("t5_post", 1'b0, 13'h0010, 13'h1FF0, 13'h0001, 13'h0003, 14'h0011, 14'h3FF3, 1'b0);
`endif

      // T6: random stream with random backpressure and occasional counter clears.
      idx = 0; cyc = 0; base = delivered;
      while (idx < 10000 && cyc < 60000) begin
         if ($urandom_range(0, 3) != 0) drive_rand();
         else din_valid = 1'b0;
         dout_ready = ($urandom_range(0, 3) != 0);
         sat_clr    = ($urandom_range(0, 31) == 0);
         step(acc);
         if (acc) idx++;
         cyc++;
      end
      sat_clr = 1'b0;
      drain();
      chk("t6_count", 32'(delivered - base), 32'(10000));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
